// File: rtl/branch_target_loader.sv
`default_nettype none
// ============================================================================
// branch_target_loader: assembles byte pairs into table targets, writes slots.
// Revision: 1.0
// ============================================================================
module branch_target_loader #(
  parameter int ENTRIES = 24,
  parameter int TW      = 10,
  parameter int BASE    = 8
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          Start,
  input  logic [7:0]    DataIn,
  input  logic          DataValid,
  output logic          DataReady,
  output logic          WrEn,
  output logic [4:0]    WrAddr,
  output logic [TW-1:0] WrData,
  output logic          Busy,
  output logic          Done,
  output logic          Error
);

  localparam int CW = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_HI    = 3'd1;
  localparam logic [2:0] S_LO    = 3'd2;
  localparam logic [2:0] S_WRITE = 3'd3;
  localparam logic [2:0] S_FIN   = 3'd4;

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    hi_q, hi_d;
  logic          err_q, err_d;
  logic [4:0]    addr_q, addr_d;
  logic [TW-1:0] data_q, data_d;
  logic          w_last;

  assign w_last = (cnt_q == CW'(ENTRIES - 1));

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      err_q   <= err_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (Start) state_d = S_HI;
      S_HI:    if (DataValid) state_d = S_LO;
      S_LO:    if (DataValid) state_d = S_WRITE;
      S_WRITE: state_d = w_last ? S_FIN : S_HI;
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Write address/data are captured on the low-byte handshake so they are
  // already stable when WrEn rises and simply hold afterwards.
  always_comb begin
    cnt_d  = cnt_q;
    hi_d   = hi_q;
    err_d  = err_q;
    addr_d = addr_q;
    data_d = data_q;
    if (state_q == S_IDLE && Start) begin
      cnt_d = '0;
      hi_d  = '0;
      err_d = 1'b0;
    end
    if (state_q == S_HI && DataValid) begin
      hi_d = DataIn[1:0];
      if (|DataIn[7:2]) err_d = 1'b1;
    end
    if (state_q == S_LO && DataValid) begin
      addr_d = 5'(BASE) + 5'(cnt_q);
      data_d = TW'({hi_q, DataIn});
    end
    if (state_q == S_WRITE && !w_last) cnt_d = cnt_q + CW'(1);
  end

  always_comb begin
    DataReady = (state_q == S_HI) || (state_q == S_LO);
    WrEn      = (state_q == S_WRITE);
    Busy      = (state_q == S_HI) || (state_q == S_LO) || (state_q == S_WRITE);
    Done      = (state_q == S_FIN);
  end

  assign WrAddr = addr_q;
  assign WrData = data_q;
  assign Error  = err_q;

endmodule
`default_nettype wire

// File: tb/tb_branch_target_loader.sv
`default_nettype none
// ============================================================================
// tb_branch_target_loader: directed loads with a write scoreboard.
// Revision: 1.0
// ============================================================================
module tb_branch_target_loader;

  localparam int ENTRIES = 24;
  localparam int TW      = 10;
  localparam int BASE    = 8;

  logic          Clk, Reset, Start, DataValid;
  logic [7:0]    DataIn;
  logic          DataReady, WrEn, Busy, Done, Error;
  logic [4:0]    WrAddr;
  logic [TW-1:0] WrData;

  logic          clk_en;
  int            checks, errors;
  int            cyc, start_cyc, done_cyc, done_cnt;
  logic          exp_err;
  logic [14:0]   exp_q[$];
  logic [14:0]   mon_e;

  branch_target_loader #(.ENTRIES(ENTRIES), .TW(TW), .BASE(BASE)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .DataIn(DataIn),
    .DataValid(DataValid), .DataReady(DataReady), .WrEn(WrEn),
    .WrAddr(WrAddr), .WrData(WrData), .Busy(Busy), .Done(Done), .Error(Error)
  );

  always begin
    #5;
    if (clk_en) Clk = ~Clk;
  end

  initial cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: every write strobe pops one expected {addr,data}.
  always @(negedge Clk) begin
    if (!Reset) begin
      if (WrEn) begin
        chk("ready_in_write", 32'(DataReady), 0);
        chk("error_at_write", 32'(Error), 32'(exp_err));
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: got addr %0d data %0h expected no write", WrAddr, WrData);
        end else begin
          mon_e = exp_q.pop_front();
          chk("wr_addr", 32'(WrAddr), 32'(mon_e[14:10]));
          chk("wr_data", 32'(WrData), 32'(mon_e[9:0]));
        end
      end
      if (Done) begin
        done_cnt++;
        done_cyc = cyc;
        chk("ready_in_fin", 32'(DataReady), 0);
        chk("busy_in_fin", 32'(Busy), 0);
        chk("error_at_done", 32'(Error), 32'(exp_err));
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input bit stall, input bit pulse_start);
    bit hs;
    int n;
    hs = 0;
    n  = 0;
    while (!hs) begin
      DataIn    = b;
      DataValid = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      Start     = pulse_start && (n == 0);
      @(negedge Clk);
      hs = DataValid && DataReady;
      @(posedge Clk);
      #1;
      n++;
      if (!hs && n > 100) begin
        checks++;
        errors++;
        $display("FAIL handshake_timeout: got no accept after %0d cycles expected accept", n);
        hs = 1;
      end
    end
    DataValid = 1'b0;
    Start     = 1'b0;
  endtask

  task automatic run_load(input bit stall, input int bad_slot, input int rst_slot, input int start_slot);
    logic [9:0] t;
    logic [7:0] hb, lb;
    done_cnt = 0;
    @(posedge Clk);
    #1;
    Start = 1'b1;
    @(posedge Clk);
    #1;
    Start     = 1'b0;
    start_cyc = cyc;
    exp_err   = 1'b0;
    chk("busy_after_start", 32'(Busy), 1);
    chk("ready_after_start", 32'(DataReady), 1);
    chk("error_cleared_by_start", 32'(Error), 0);
    for (int k = 0; k < ENTRIES; k++) begin
      t  = 10'((k * 37) % 1024);
      hb = {6'b0, t[9:8]};
      lb = t[7:0];
      if (k == bad_slot) begin
        hb = 8'hFE;
        lb = 8'h12;
        t  = 10'h212;
      end
      send_byte(hb, stall, 1'b0);
      if (k == bad_slot) begin
        exp_err = 1'b1;
        chk("error_after_bad_hi", 32'(Error), 1);
      end
      if (k == rst_slot) begin
        Reset   = 1'b1;
        exp_err = 1'b0;
        #1;
        chk("busy_in_reset", 32'(Busy), 0);
        chk("ready_in_reset", 32'(DataReady), 0);
        chk("wren_in_reset", 32'(WrEn), 0);
        chk("wraddr_in_reset", 32'(WrAddr), 0);
        chk("error_in_reset", 32'(Error), 0);
        repeat (3) @(posedge Clk);
        #1;
        Reset = 1'b0;
        repeat (3) @(posedge Clk);
        #1;
        chk("busy_after_reset", 32'(Busy), 0);
        chk("pending_after_reset", 32'(exp_q.size()), 0);
        return;
      end
      send_byte(lb, stall, k == start_slot);
      exp_q.push_back({5'(BASE + k), t});
    end
    for (int n = 0; n < 20 && done_cnt == 0; n++) begin
      @(posedge Clk);
      #1;
    end
    repeat (3) @(posedge Clk);
    #1;
    chk("done_count", 32'(done_cnt), 1);
    chk("pending_writes", 32'(exp_q.size()), 0);
    chk("error_after_load", 32'(Error), 32'(exp_err));
    chk("busy_after_load", 32'(Busy), 0);
    if (!stall) chk("done_latency", 32'(done_cyc - start_cyc), 72);
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    done_cnt  = 0;
    exp_err   = 1'b0;
    clk_en    = 1'b0;
    Clk       = 1'b0;
    Reset     = 1'b0;
    Start     = 1'b0;
    DataIn    = 8'h00;
    DataValid = 1'b0;
    #3;
    Reset = 1'b1;
    #1;
    chk("async_reset_outputs", 32'({DataReady, WrEn, WrAddr, WrData, Busy, Done, Error}), 0);
    #5;
    Reset  = 1'b0;
    clk_en = 1'b1;
    repeat (3) @(posedge Clk);
    #1;
    chk("idle_outputs", 32'({DataReady, WrEn, WrAddr, WrData, Busy, Done, Error}), 0);

    run_load(1'b0, -1, -1, -1);
    run_load(1'b1, -1, -1, -1);
    run_load(1'b0,  5, -1, -1);
    run_load(1'b0, -1, 10, -1);
    run_load(1'b0, -1, -1,  3);
    run_load(1'b1,  5, -1,  3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/branch_target_loader.md
# branch_target_loader

Runtime writer for the branch-target lookup table. It accepts a byte stream over a valid/ready handshake and assembles each pair of bytes into a 10-bit branch target. Each target is written into the next table slot, addressed by the same 5-bit {ProgState, addr} code the lookup side decodes. The block sits between the program-load path and the target table, so targets can be reloaded without re-reading the init file.

## Interface
Parameters:
- ENTRIES, 24: number of table slots to fill per load.
- TW, 10: target width in bits.
- BASE, 8: write code of slot 0 (code 5'b01_000).

Ports:
- Clk  in  1  clock; all state updates on rising edge.
- Reset  in  1  asynchronous, active-high reset.
- Start  in  1  single-cycle request to begin a load; honoured only in IDLE.
- DataIn  in  8  stream byte.
- DataValid  in  1  DataIn is valid this cycle.
- DataReady  out  1  block accepts a byte this cycle.
- WrEn  out  1  table write strobe, one cycle per entry.
- WrAddr  out  5  table write code {ProgState, addr}.
- WrData  out  TW  assembled target.
- Busy  out  1  load in progress.
- Done  out  1  one-cycle pulse when the last entry is written.
- Error  out  1  sticky malformed-high-byte flag; cleared on accepted Start.

## Operation
- **Byte format.** Each entry is two bytes, high byte first.
  - High byte: bits [1:0] give WrData[9:8]. Bits [7:2] must be 0.
  - Low byte: gives WrData[7:0].
- **Slot addressing.** Slot k (0..ENTRIES-1) is written at WrAddr = BASE + k, so codes run 8..31 in order. Arithmetic is 5-bit; no wrap occurs for the default parameters.
- **FSM states:** IDLE, HI, LO, WRITE, FIN.
  - IDLE: Start=1 moves to HI, clears slot counter and Error, and sets Busy=1.
  - HI: DataReady=1. A handshake (DataValid & DataReady at the edge) latches bits [1:0] and moves to LO.
    - Any of bits [7:2] nonzero sets Error.
    - The byte is still consumed and the entry is still written.
  - LO: DataReady=1. A handshake latches the low byte and moves to WRITE.
  - WRITE: WrEn=1 for one cycle, with WrAddr/WrData stable.
    - If the counter equals ENTRIES-1, go to FIN.
    - Otherwise increment the counter and go to HI.
  - FIN: Done=1 for one cycle and Busy=0; next state is IDLE.
- **Stalls.** While DataValid=0 the FSM holds in HI or LO with no limit.
- **Start outside IDLE.** Ignored; the load continues unaffected.
- **Reset.** Asserting Reset at any time returns the FSM to IDLE asynchronously.
  - Counter, latched bytes and Error are cleared.
  - A partial entry is discarded and never written.
  - Table contents already written stay as they are; the table is not owned by this block.

## Timing
- All outputs are registered or decoded from the state register. There is no combinational path from DataValid or DataIn to any output.
- Reset values: DataReady=0, WrEn=0, WrAddr=0, WrData=0, Busy=0, Done=0, Error=0.
- **Start latency.** Start sampled at edge E gives Busy=1 and DataReady=1 in the cycle after E.
- **Write latency.** Low byte accepted at edge N gives WrEn=1 in the cycle after N, then DataReady=1 again one cycle later.
- **Throughput.** 3 cycles per entry with DataValid held high. A full load is 72 cycles from Start acceptance to the last WrEn, with Done one cycle after that.
- WrAddr and WrData hold their last written values outside WRITE. WrEn is 0 outside WRITE.
- Error changes only at the HI handshake, an accepted Start, or Reset.

## Test plan
- **Reset:** assert Reset mid-cycle with no clock edge.
  - All outputs read 0 immediately.
  - After release, an idle Clk keeps them at 0.
- **Full load:** Start, then 48 bytes with DataValid=1 encoding targets k*37 mod 1024.
  - 24 WrEn pulses at WrAddr 8..31 with matching WrData.
  - Done pulses exactly once, 73 cycles after Start acceptance.
  - Error=0.
- **Stalls:** toggle DataValid randomly (~50%) during the load.
  - Same 24 writes in the same order.
  - No byte is dropped or duplicated.
  - DataReady never rises in WRITE or FIN.
- **Bad high byte:** slot 5 high byte = 8'hFE, low = 8'h12.
  - WrData=10'h212 at WrAddr 13.
  - Error=1 from the next cycle and through Done.
  - Next Start clears Error.
- **Reset mid-load:** assert Reset after the high byte of slot 10.
  - No write to code 18.
  - Busy=0.
  - A following full load restarts at WrAddr 8.
- **Start while busy:** pulse Start during slot 3.
  - Counter is not reset.
  - Writes continue at code 11 onward.
  - Exactly one Done pulse.
